// File: rtl/systolic_array_ctrl_if.sv
// Handshake and array-side bundle for the systolic array sequencer.
// master = layer controller / PE array side, slave = sequencer.
interface systolic_array_ctrl_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int datawidth = 11,
    parameter int MAX_VEC   = 16
);
    localparam int VW = $clog2(MAX_VEC + 1);

    logic                      start;
    logic                      train_req;
    logic [VW-1:0]             num_vec;
    logic                      upd_valid;
    logic                      upd_ready;
    logic [datawidth-1:0]      upd_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [COLS*datawidth-1:0] in_data;
    logic [COLS*datawidth-1:0] arr_value;
    logic [ROWS*COLS-1:0]      arr_train_en;
    logic [datawidth-1:0]      arr_weight_update;
    logic                      arr_rst_vals;
    logic                      out_valid;
    logic                      busy;
    logic                      done;

    modport master (
        output start, train_req, num_vec, upd_valid, upd_data, in_valid, in_data,
        input  upd_ready, in_ready, arr_value, arr_train_en, arr_weight_update,
               arr_rst_vals, out_valid, busy, done
    );

    modport slave (
        input  start, train_req, num_vec, upd_valid, upd_data, in_valid, in_data,
        output upd_ready, in_ready, arr_value, arr_train_en, arr_weight_update,
               arr_rst_vals, out_valid, busy, done
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Systolic array sequencer: weight load, accumulator clear, skewed input
// streaming and east-edge result tracking for a ROWS x COLS MAC array.

// One column lane: a zero-reset delay line of DEPTH registers.
module systolic_array_ctrl_lane #(
    parameter int W     = 11,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_overall_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] sr;

    // Shift the lane value toward the array by one stage per cycle.
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

module systolic_array_ctrl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int datawidth = 11,
    parameter int MAX_VEC   = 16,
    parameter int PE_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_overall_n,
    systolic_array_ctrl_if.slave  bus
);
    localparam int VW     = $clog2(MAX_VEC + 1);
    localparam int NPE    = ROWS * COLS;
    localparam int IW     = $clog2(NPE + 1);
    // Accept -> out_valid distance: one register to lane 0, then COLS PE hops.
    localparam int STAGES = 1 + COLS * PE_LAT;

    typedef enum logic [2:0] {IDLE, UPDATE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                            state;
    logic [IW-1:0]                     idx;
    logic [VW-1:0]                     vec_cnt;
    logic [VW-1:0]                     nvec_q;
    logic [STAGES:1]                   vld_pipe;
    logic [COLS-1:0][datawidth-1:0]    lane_q;
    logic                              upd_acc;
    logic                              in_acc;

    assign upd_acc = bus.upd_valid & bus.upd_ready;
    assign in_acc  = bus.in_valid & bus.in_ready;

    // Sequencer FSM with registered outputs. After the last weight word the
    // FSM spends one extra UPDATE cycle (upd_ready already low) so the final
    // train_en strobe never overlaps the accumulator clear.
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state                 <= IDLE;
            idx                   <= '0;
            vec_cnt               <= '0;
            nvec_q                <= '0;
            bus.upd_ready         <= 1'b0;
            bus.in_ready          <= 1'b0;
            bus.arr_train_en      <= '0;
            bus.arr_weight_update <= '0;
            bus.arr_rst_vals      <= 1'b0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
        end else begin
            bus.arr_train_en <= '0;
            bus.done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        nvec_q   <= bus.num_vec;
                        bus.busy <= 1'b1;
                        if (bus.train_req) begin
                            state         <= UPDATE;
                            idx           <= '0;
                            bus.upd_ready <= 1'b1;
                        end else begin
                            state            <= CLEAR;
                            bus.arr_rst_vals <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    if (idx == IW'(NPE)) begin
                        state            <= CLEAR;
                        bus.arr_rst_vals <= 1'b1;
                    end else if (upd_acc) begin
                        bus.arr_weight_update <= bus.upd_data;
                        bus.arr_train_en      <= NPE'(1) << idx;
                        idx                   <= idx + IW'(1);
                        if (idx == IW'(NPE - 1)) bus.upd_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    bus.arr_rst_vals <= 1'b0;
                    vec_cnt          <= '0;
                    if (nvec_q != '0) begin
                        state        <= FEED;
                        bus.in_ready <= 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                FEED: begin
                    if (in_acc) begin
                        vec_cnt <= vec_cnt + VW'(1);
                        if ((vec_cnt + VW'(1)) == nvec_q) begin
                            state        <= DRAIN;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Leave once only the final stage can still hold a tag;
                    // it exits on this edge, so done follows the last out_valid.
                    if (vld_pipe[STAGES-1:1] == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accept tags travel alongside the data; bubbles and drain cycles shift in 0.
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) vld_pipe <= '0;
        else                vld_pipe <= {vld_pipe[STAGES-1:1], in_acc};
    end

    assign bus.out_valid = vld_pipe[STAGES];

    // Lane c is delayed c*PE_LAT cycles beyond lane 0 to form the systolic skew.
    genvar c;
    generate
        for (c = 0; c < COLS; c++) begin : g_lane
            logic [datawidth-1:0] lane_in;
            assign lane_in = in_acc ? bus.in_data[c*datawidth +: datawidth] : '0;
            systolic_array_ctrl_lane #(
                .W     (datawidth),
                .DEPTH (1 + c * PE_LAT)
            ) u_lane (
                .clk           (clk),
                .rst_overall_n (rst_overall_n),
                .d             (lane_in),
                .q             (lane_q[c])
            );
        end
    endgenerate

    assign bus.arr_value = lane_q;
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: randomized stimulus against a cycle-timeline
// reference model built from the phase rules (accept lists, fixed latencies).
module tb_systolic_array_ctrl;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int DW      = 11;
    localparam int MAX_VEC = 16;
    localparam int PE_LAT  = 1;
    localparam int VW      = $clog2(MAX_VEC + 1);
    localparam int NPE     = ROWS * COLS;
    localparam int CW      = COLS * DW;
    localparam int LAT     = 1 + COLS * PE_LAT;
    localparam int LOG     = 320;

    logic clk = 1'b0;
    logic rst_overall_n = 1'b1;
    always #5 clk = ~clk;

    systolic_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .datawidth(DW), .MAX_VEC(MAX_VEC)) bus ();

    systolic_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .datawidth(DW), .MAX_VEC(MAX_VEC), .PE_LAT(PE_LAT)
    ) dut (
        .clk           (clk),
        .rst_overall_n (rst_overall_n),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus per cycle
    bit            up [LOG];
    bit            vp [LOG];
    logic [DW-1:0] ud [LOG];
    logic [CW-1:0] id [LOG];
    // expected per cycle
    logic           e_busy [LOG], e_done [LOG], e_ov [LOG], e_rst [LOG], e_ur [LOG], e_ir [LOG];
    logic [NPE-1:0] e_te [LOG];
    logic [DW-1:0]  e_w [LOG];
    logic [CW-1:0]  e_val [LOG];
    // observed per cycle
    logic           o_busy [LOG], o_done [LOG], o_ov [LOG], o_rst [LOG], o_ur [LOG], o_ir [LOG];
    logic [NPE-1:0] o_te [LOG];
    logic [DW-1:0]  o_w [LOG];
    logic [CW-1:0]  o_val [LOG];
    int d_end, n_log;

    task automatic idle_inputs();
        bus.start = 1'b0; bus.train_req = 1'b0; bus.num_vec = '0;
        bus.upd_valid = 1'b0; bus.upd_data = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    endtask

    // umode: 0 = upd_valid low every 3rd cycle, else random.
    // vmode: 0 = continuous, 1 = one valid then 2-cycle gap, else random.
    task automatic set_patterns(input int umode, input int vmode);
        for (int t = 0; t < LOG; t++) begin
            up[t] = (umode == 0) ? (t % 3 != 2) : ($urandom_range(0, 3) != 0);
            case (vmode)
                0:       vp[t] = 1'b1;
                1:       vp[t] = (t % 3 == 0);
                default: vp[t] = ($urandom_range(0, 2) != 0);
            endcase
            ud[t] = DW'($urandom);
            id[t] = CW'({$urandom, $urandom});
        end
    endtask

    // Timeline model. Cycle 0 carries start; phases follow from the accept
    // rules: weight k strobes the cycle after its accept, the clear is two
    // cycles after the last weight (cycle 1 without training), each vector
    // shows lane c at accept+1+c*PE_LAT and out_valid at accept+LAT, done
    // comes one cycle after the last out_valid (clear+2 with no vectors).
    task automatic build_model(input bit train, input int nvec, input bit seq_w);
        int t, k, n, cc;
        int acc[$];
        for (t = 0; t < LOG; t++) begin
            e_busy[t] = 0; e_done[t] = 0; e_ov[t] = 0; e_rst[t] = 0; e_ur[t] = 0; e_ir[t] = 0;
            e_te[t] = '0; e_w[t] = '0; e_val[t] = '0;
        end
        if (train) begin
            t = 1; k = 0;
            while (k < NPE && t < LOG - 48) begin
                e_ur[t] = 1;
                if (up[t]) begin
                    if (seq_w) ud[t] = DW'(k + 1);
                    e_te[t+1] = NPE'(1) << k;
                    e_w[t+1]  = ud[t];
                    k++;
                end
                t++;
            end
            cc = t + 1;
        end else begin
            cc = 1;
        end
        e_rst[cc] = 1;
        if (nvec > 0) begin
            t = cc + 1; n = 0;
            while (n < nvec && t < LOG - 48) begin
                e_ir[t] = 1;
                if (vp[t]) begin acc.push_back(t); n++; end
                t++;
            end
            d_end = (t - 1) + LAT + 1;
        end else begin
            d_end = cc + 2;
        end
        for (t = 1; t <= d_end; t++) e_busy[t] = 1;
        e_done[d_end] = 1;
        foreach (acc[i]) begin
            e_ov[acc[i] + LAT] = 1;
            for (int c = 0; c < COLS; c++)
                e_val[acc[i] + 1 + c*PE_LAT][c*DW +: DW] = id[acc[i]][c*DW +: DW];
        end
    endtask

    // Drive one batch (cycle 0 = start) and log outputs at each negedge.
    // hold keeps start high with different settings while busy.
    task automatic run_batch(input bit train, input int nvec, input bit hold, input int tail);
        for (int t = 0; t <= d_end + tail; t++) begin
            @(negedge clk);
            o_busy[t] = bus.busy; o_done[t] = bus.done; o_ov[t] = bus.out_valid;
            o_rst[t] = bus.arr_rst_vals; o_ur[t] = bus.upd_ready; o_ir[t] = bus.in_ready;
            o_te[t] = bus.arr_train_en; o_w[t] = bus.arr_weight_update; o_val[t] = bus.arr_value;
            if (t < d_end) begin
                bus.start     = (t == 0) || hold;
                bus.train_req = (t == 0) ? train : ~train;
                bus.num_vec   = (t == 0) ? VW'(nvec) : VW'(MAX_VEC - nvec);
                bus.upd_valid = up[t]; bus.upd_data = ud[t];
                bus.in_valid  = vp[t]; bus.in_data  = id[t];
            end else begin
                idle_inputs();
            end
        end
        n_log = d_end + tail;
    endtask

    task automatic test_reset();
        logic [2*CW+NPE+DW+4:0] snap;
        idle_inputs();
        #2 rst_overall_n = 1'b0;
        #3;
        snap = {bus.upd_ready, bus.in_ready, bus.arr_value, bus.arr_train_en,
                bus.arr_weight_update, bus.arr_rst_vals, bus.out_valid, bus.busy, bus.done, bus.in_data};
        checks++;
        if (snap[2*CW+NPE+DW+4:CW] !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", snap[2*CW+NPE+DW+4:CW]);
        end
        repeat (2) @(negedge clk);
        rst_overall_n = 1'b1;
        // start a 5-vector batch and abort it after the 2nd accept
        @(negedge clk);
        bus.start = 1'b1; bus.train_req = 1'b0; bus.num_vec = VW'(5);
        bus.in_valid = 1'b1; bus.in_data = CW'({$urandom, $urandom}) | CW'(1);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.in_ready} !== 2'b11) begin
            errors++; $display("FAIL midfeed_state got busy/in_ready %b exp 11", {bus.busy, bus.in_ready});
        end
        rst_overall_n = 1'b0;
        #1;
        snap = {bus.upd_ready, bus.in_ready, bus.arr_value, bus.arr_train_en,
                bus.arr_weight_update, bus.arr_rst_vals, bus.out_valid, bus.busy, bus.done, bus.in_data};
        checks++;
        if (snap[2*CW+NPE+DW+4:CW] !== '0) begin
            errors++; $display("FAIL abort_outputs got %h exp 0", snap[2*CW+NPE+DW+4:CW]);
        end
        @(negedge clk);
        rst_overall_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.out_valid, bus.in_ready} !== 4'b0) begin
                errors++;
                $display("FAIL post_abort_idle cyc %0d got %b exp 0000", i,
                         {bus.busy, bus.done, bus.out_valid, bus.in_ready});
            end
        end
        // clean batch after the abort
        set_patterns(1, 2);
        build_model(0, 5, 0);
        run_batch(0, 5, 0, 3);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if (o_ov[t] !== e_ov[t]) begin errors++; $display("FAIL clean_out_valid cyc %0d got %b exp %b", t, o_ov[t], e_ov[t]); end
            checks++;
            if (o_val[t] !== e_val[t]) begin errors++; $display("FAIL clean_lanes cyc %0d got %h exp %h", t, o_val[t], e_val[t]); end
            checks++;
            if ({o_busy[t], o_done[t]} !== {e_busy[t], e_done[t]}) begin
                errors++; $display("FAIL clean_busy_done cyc %0d got %b%b exp %b%b", t, o_busy[t], o_done[t], e_busy[t], e_done[t]);
            end
        end
    endtask

    task automatic test_weight_load();
        int pulses = 0, clears = 0;
        set_patterns(0, 0);
        build_model(1, 2, 1);
        run_batch(1, 2, 0, 3);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if (o_te[t] !== e_te[t]) begin errors++; $display("FAIL train_en cyc %0d got %h exp %h", t, o_te[t], e_te[t]); end
            if (e_te[t] != '0) begin
                checks++;
                if (o_w[t] !== e_w[t]) begin errors++; $display("FAIL weight cyc %0d got %0d exp %0d", t, o_w[t], e_w[t]); end
            end
            checks++;
            if (o_rst[t] !== e_rst[t]) begin errors++; $display("FAIL rst_vals cyc %0d got %b exp %b", t, o_rst[t], e_rst[t]); end
            checks++;
            if (o_ur[t] !== e_ur[t]) begin errors++; $display("FAIL upd_ready cyc %0d got %b exp %b", t, o_ur[t], e_ur[t]); end
            checks++;
            if ((o_te[t] != '0) && o_rst[t]) begin errors++; $display("FAIL te_rst_overlap cyc %0d got both high exp exclusive", t); end
            if (o_te[t] != '0) pulses++;
            if (o_rst[t]) clears++;
        end
        checks++;
        if (pulses != NPE) begin errors++; $display("FAIL train_pulse_count got %0d exp %0d", pulses, NPE); end
        checks++;
        if (clears != 1) begin errors++; $display("FAIL clear_count got %0d exp 1", clears); end
    endtask

    task automatic test_skew();
        logic [CW-1:0] skew_word;
        int nov = 0;
        skew_word = {11'd4, 11'd3, 11'd2, 11'd1};
        set_patterns(1, 0);
        for (int t = 0; t < LOG; t++) id[t] = skew_word;
        build_model(0, 1, 0);
        run_batch(0, 1, 0, 3);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if (o_val[t] !== e_val[t]) begin errors++; $display("FAIL skew_lanes cyc %0d got %h exp %h", t, o_val[t], e_val[t]); end
            checks++;
            if (o_ov[t] !== e_ov[t]) begin errors++; $display("FAIL skew_out_valid cyc %0d got %b exp %b", t, o_ov[t], e_ov[t]); end
            checks++;
            if (o_done[t] !== e_done[t]) begin errors++; $display("FAIL skew_done cyc %0d got %b exp %b", t, o_done[t], e_done[t]); end
            if (o_ov[t]) nov++;
        end
        checks++;
        if (nov != 1) begin errors++; $display("FAIL skew_ov_count got %0d exp 1", nov); end
    endtask

    task automatic test_stalls();
        int nov = 0;
        set_patterns(1, 1);
        build_model(0, 3, 0);
        run_batch(0, 3, 0, 3);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if (o_ov[t] !== e_ov[t]) begin errors++; $display("FAIL stall_out_valid cyc %0d got %b exp %b", t, o_ov[t], e_ov[t]); end
            checks++;
            if (o_val[t] !== e_val[t]) begin errors++; $display("FAIL stall_lanes cyc %0d got %h exp %h", t, o_val[t], e_val[t]); end
            checks++;
            if (o_ir[t] !== e_ir[t]) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b exp %b", t, o_ir[t], e_ir[t]); end
            if (o_ov[t]) nov++;
        end
        checks++;
        if (nov != 3) begin errors++; $display("FAIL stall_ov_count got %0d exp 3", nov); end
    endtask

    task automatic test_edge();
        set_patterns(1, 2);
        build_model(0, 0, 0);
        run_batch(0, 0, 1, 4);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if ({o_busy[t], o_done[t], o_rst[t]} !== {e_busy[t], e_done[t], e_rst[t]}) begin
                errors++;
                $display("FAIL edge_busy_done_rst cyc %0d got %b%b%b exp %b%b%b", t,
                         o_busy[t], o_done[t], o_rst[t], e_busy[t], e_done[t], e_rst[t]);
            end
            checks++;
            if ({o_ov[t], o_ir[t], o_ur[t]} !== {e_ov[t], e_ir[t], e_ur[t]}) begin
                errors++;
                $display("FAIL edge_ov_ready cyc %0d got %b%b%b exp %b%b%b", t,
                         o_ov[t], o_ir[t], o_ur[t], e_ov[t], e_ir[t], e_ur[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nov = 0;
        set_patterns(1, 0);
        build_model(0, MAX_VEC, 0);
        run_batch(0, MAX_VEC, 0, 0);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if ({o_ov[t], o_done[t], o_busy[t]} !== {e_ov[t], e_done[t], e_busy[t]}) begin
                errors++;
                $display("FAIL full_ov_done_busy cyc %0d got %b%b%b exp %b%b%b", t,
                         o_ov[t], o_done[t], o_busy[t], e_ov[t], e_done[t], e_busy[t]);
            end
            if (o_ov[t]) nov++;
        end
        checks++;
        if (nov != MAX_VEC) begin errors++; $display("FAIL full_ov_count got %0d exp %0d", nov, MAX_VEC); end
        // start again in the IDLE cycle right after DONE
        set_patterns(2, 0);
        build_model(1, MAX_VEC, 0);
        run_batch(1, MAX_VEC, 0, 3);
        for (int t = 0; t <= n_log; t++) begin
            checks++;
            if ({o_ov[t], o_done[t], o_busy[t]} !== {e_ov[t], e_done[t], e_busy[t]}) begin
                errors++;
                $display("FAIL b2b_ov_done_busy cyc %0d got %b%b%b exp %b%b%b", t,
                         o_ov[t], o_done[t], o_busy[t], e_ov[t], e_done[t], e_busy[t]);
            end
            checks++;
            if (o_te[t] !== e_te[t]) begin errors++; $display("FAIL b2b_train_en cyc %0d got %h exp %h", t, o_te[t], e_te[t]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            bit tr;
            int nv;
            tr = 1'($urandom_range(0, 1));
            nv = $urandom_range(1, MAX_VEC);
            set_patterns(1, 2);
            build_model(tr, nv, 0);
            run_batch(tr, nv, 0, 3);
            for (int t = 0; t <= n_log; t++) begin
                checks++;
                if ({o_busy[t], o_done[t], o_ov[t], o_rst[t], o_ur[t], o_ir[t]} !==
                    {e_busy[t], e_done[t], e_ov[t], e_rst[t], e_ur[t], e_ir[t]}) begin
                    errors++;
                    $display("FAIL rand%0d_ctrl cyc %0d got %b exp %b", it, t,
                             {o_busy[t], o_done[t], o_ov[t], o_rst[t], o_ur[t], o_ir[t]},
                             {e_busy[t], e_done[t], e_ov[t], e_rst[t], e_ur[t], e_ir[t]});
                end
                checks++;
                if (o_te[t] !== e_te[t]) begin errors++; $display("FAIL rand%0d_train_en cyc %0d got %h exp %h", it, t, o_te[t], e_te[t]); end
                if (e_te[t] != '0) begin
                    checks++;
                    if (o_w[t] !== e_w[t]) begin errors++; $display("FAIL rand%0d_weight cyc %0d got %h exp %h", it, t, o_w[t], e_w[t]); end
                end
                checks++;
                if (o_val[t] !== e_val[t]) begin errors++; $display("FAIL rand%0d_lanes cyc %0d got %h exp %h", it, t, o_val[t], e_val[t]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_skew();
        test_stalls();
        test_edge();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
